dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-ported data memory.
- Accepts word read/write requests from two independent masters (e.g. load/store unit and DMA/debug port).
- Grants them round-robin and drives the memory's read/write/done handshake, one transaction at a time.
- Returns read data and a one-cycle ack to the owning requester; converts misaligned or stalled accesses into an error ack.

---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for two masters sharing one data memory port.
// One transaction at a time; misaligned or timed-out accesses complete with an error ack.
module dmem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done_r,
    input  logic              mem_done_w,
    output logic              busy,
    output logic              owner
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic              rr_ptr;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;

    logic              any_req;
    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              done_hit;
    logic              resp_go;
    logic              resp_err;
    logic              resp_who;
    logic [DATA_W-1:0] resp_data;

    assign any_req   = r0_req | r1_req;
    assign winner    = (r0_req & r1_req) ? rr_ptr : r1_req;
    assign sel_we    = winner ? r1_we : r0_we;
    assign sel_addr  = winner ? r1_addr : r0_addr;
    assign sel_wdata = winner ? r1_wdata : r0_wdata;
    assign done_hit  = we_q ? mem_done_w : mem_done_r;
    assign busy      = (state != IDLE);

    // Next response, registered into the owner's ack/err/rdata below
    always_comb begin
        resp_go   = 1'b0;
        resp_err  = 1'b0;
        resp_who  = owner;
        resp_data = '0;
        unique case (state)
            IDLE: begin
                if (any_req && sel_addr[1:0] != 2'b00) begin
                    resp_go  = 1'b1;
                    resp_err = 1'b1;
                    resp_who = winner;
                end
            end
            WAIT: begin
                if (done_hit) begin
                    resp_go   = 1'b1;
                    resp_data = we_q ? '0 : mem_rdata;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    resp_go  = 1'b1;
                    resp_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            we_q      <= 1'b0;
            cnt       <= '0;
            owner     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r0_ack    <= 1'b0;
            r0_err    <= 1'b0;
            r0_rdata  <= '0;
            r1_ack    <= 1'b0;
            r1_err    <= 1'b0;
            r1_rdata  <= '0;
        end else begin
            r0_ack   <= resp_go & ~resp_who;
            r0_err   <= resp_go & ~resp_who & resp_err;
            r0_rdata <= (resp_go && !resp_who) ? resp_data : '0;
            r1_ack   <= resp_go & resp_who;
            r1_err   <= resp_go & resp_who & resp_err;
            r1_rdata <= (resp_go && resp_who) ? resp_data : '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        we_q      <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        rr_ptr    <= ~winner;
                        cnt       <= '0;
                        if (sel_addr[1:0] != 2'b00) begin
                            state <= RESP;
                        end else begin
                            state     <= WAIT;
                            mem_read  <= ~sel_we;
                            mem_write <= sel_we;
                        end
                    end
                end
                WAIT: begin
                    if (resp_go) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: transaction table, fairness, timeout and
// asynchronous-reset sequences against a small behavioural memory.
module tb_dmem_arbiter;
    logic        clock = 0;
    logic        reset = 1;
    logic        r0_req = 0, r0_we = 0;
    logic [9:0]  r0_addr = 0;
    logic [31:0] r0_wdata = 0;
    logic        r0_ack, r0_err;
    logic [31:0] r0_rdata;
    logic        r1_req = 0, r1_we = 0;
    logic [9:0]  r1_addr = 0;
    logic [31:0] r1_wdata = 0;
    logic        r1_ack, r1_err;
    logic [31:0] r1_rdata;
    logic        mem_read, mem_write;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'hA5A5_A5A5;
    logic        mem_done_r = 0, mem_done_w = 0;
    logic        busy, owner;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_done_r(mem_done_r), .mem_done_w(mem_done_w),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    // Behavioural memory: word i initially holds i; done after lat commanded cycles
    logic [31:0] mem [256];
    int lat = 1;
    bit rd_en = 1, wr_en = 1, stray_w = 0;
    int wcnt = 0;

    initial for (int i = 0; i < 256; i++) mem[i] = i;

    always @(negedge clock) begin
        mem_done_r = 0;
        mem_done_w = 0;
        mem_rdata  = 32'hA5A5_A5A5;
        if (mem_read || mem_write) begin
            wcnt++;
            if (wcnt >= lat) begin
                if (mem_read && rd_en) begin
                    mem_done_r = 1;
                    mem_rdata  = mem[mem_addr[9:2]];
                end
                if (mem_write && wr_en) begin
                    mem_done_w = 1;
                    mem[mem_addr[9:2]] = mem_wdata;
                end
            end
        end else begin
            wcnt = 0;
        end
        if (stray_w) mem_done_w = 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        who;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic drive(input logic who, input logic req, input logic we,
                         input logic [9:0] addr, input logic [31:0] wdata);
        if (who) begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end else begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end
    endtask

    // Single requester transaction with cycle-exact ack timing
    task automatic txn(input vec_t v, input string tag);
        bit got = 0, saw_cmd = 0;
        int at = -1;
        lat = v.lat;
        @(negedge clock);
        drive(v.who, 1, v.we, v.addr, v.wdata);
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clock); #1;
            if (mem_read && mem_write) chk({tag, " rw_both"}, 1, 0);
            if (c == 0) begin
                chk({tag, " busy"}, busy, 1);
                chk({tag, " owner"}, owner, v.who);
            end
            if (mem_read || mem_write) begin
                saw_cmd = 1;
                if (mem_write !== v.we || mem_addr !== v.addr ||
                    (v.we && mem_wdata !== v.wdata))
                    chk({tag, " cmd"}, {mem_write, mem_addr, mem_wdata},
                        {v.we, v.addr, v.we ? v.wdata : mem_wdata});
            end
            if ((v.who ? r0_ack : r1_ack) === 1'b1) chk({tag, " other_ack"}, 1, 0);
            if ((v.who ? r1_ack : r0_ack) === 1'b1) begin
                got = 1;
                at  = c;
                chk({tag, " err"}, v.who ? r1_err : r0_err, v.err);
                chk({tag, " rdata"}, v.who ? r1_rdata : r0_rdata, v.rdata);
                chk({tag, " cmd_off"}, {mem_read, mem_write}, 0);
            end
        end
        chk({tag, " ack_cycle"}, at, v.err ? 0 : v.lat);
        chk({tag, " saw_cmd"}, saw_cmd, !v.err);
        @(posedge clock); #1;
        chk({tag, " ack_pulse"}, v.who ? r1_ack : r0_ack, 0);
        chk({tag, " idle"}, busy, 0);
        drive(v.who, 0, 0, 0, 0);
    endtask

    // Both requesters read; record grant order over ntx acks
    task automatic pair(input bit keep, input int ntx, input string tag);
        int   n = 0;
        bit   pd0 = 0, pd1 = 0, stop = 0;
        logic seq [8];
        lat = 1;
        @(negedge clock);
        drive(0, 1, 0, 10'h010, 0);
        drive(1, 1, 0, 10'h030, 0);
        for (int c = 0; c < 200 && !stop; c++) begin
            @(posedge clock); #1;
            if (pd0) begin r0_req = 0; pd0 = 0; end
            if (pd1) begin r1_req = 0; pd1 = 0; end
            if (n >= ntx) stop = 1;
            if (r0_ack && n < 8) begin
                seq[n] = 0; n++;
                chk({tag, " r0_rdata"}, r0_rdata, 32'd4);
                if (!keep || n >= ntx) pd0 = 1;
                if (keep && n >= ntx) pd1 = 1;
            end
            if (r1_ack && n < 8) begin
                seq[n] = 1; n++;
                chk({tag, " r1_rdata"}, r1_rdata, 32'd12);
                if (!keep || n >= ntx) pd1 = 1;
                if (keep && n >= ntx) pd0 = 1;
            end
        end
        chk({tag, " count"}, n, ntx);
        for (int i = 0; i < ntx && i < n; i++)
            chk($sformatf("%s grant%0d", tag, i), seq[i], i % 2);
        r0_req = 0;
        r1_req = 0;
        repeat (3) @(posedge clock);
        #1 chk({tag, " idle"}, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        vecs[0] = '{0, 0, 10'h010, 32'h0,         1, 0, 32'd4};
        vecs[1] = '{1, 1, 10'h020, 32'hDEADBEEF,  1, 0, 32'h0};
        vecs[2] = '{1, 0, 10'h020, 32'h0,         3, 0, 32'hDEADBEEF};
        vecs[3] = '{0, 0, 10'h013, 32'h0,         1, 1, 32'h0};
        vecs[4] = '{0, 1, 10'h044, 32'h12345678,  2, 0, 32'h0};
        vecs[5] = '{1, 0, 10'h044, 32'h0,         1, 0, 32'h12345678};
        vecs[6] = '{1, 1, 10'h002, 32'hFFFFFFFF,  1, 1, 32'h0};
        vecs[7] = '{0, 0, 10'h3FC, 32'h0,         4, 0, 32'd255};

        #1;
        chk("reset busy", busy, 0);
        chk("reset cmd", {mem_read, mem_write}, 0);
        chk("reset acks", {r0_ack, r1_ack, r0_err, r1_err}, 0);
        chk("reset rdata", {r0_rdata, r1_rdata}, 0);
        repeat (2) @(negedge clock);
        reset = 0;
        #1 chk("reset owner", owner, 0);

        for (int i = 0; i < 8; i++) txn(vecs[i], $sformatf("vec%0d", i));
        chk("mem 0x020", mem[8], 32'hDEADBEEF);
        chk("mem 0x000 untouched", mem[0], 32'd0);

        do_reset();
        pair(0, 2, "pair_a");
        pair(0, 2, "pair_b");
        pair(1, 4, "hold4");

        begin : timeout_seq
            int hi = 0, at = -1;
            bit got = 0;
            rd_en = 0;
            lat = 1;
            @(negedge clock);
            drive(1, 1, 0, 10'h010, 0);
            for (int c = 0; c < 60 && !got; c++) begin
                @(posedge clock); #1;
                if (c == 3) stray_w = 1;
                if (c == 5) stray_w = 0;
                if (mem_read) hi++;
                if (r0_ack) chk("tmo r0_ack", r0_ack, 0);
                if (r1_ack) begin
                    got = 1;
                    at  = c;
                    chk("tmo err", r1_err, 1);
                    chk("tmo rdata", r1_rdata, 0);
                end
            end
            chk("tmo read_cycles", hi, 16);
            chk("tmo ack_cycle", at, 16);
            @(posedge clock); #1;
            drive(1, 0, 0, 0, 0);
            rd_en = 1;
        end

        begin : reset_seq
            bit acked = 0;
            wr_en = 0;
            @(negedge clock);
            drive(0, 1, 1, 10'h050, 32'hCAFEF00D);
            repeat (3) begin
                @(posedge clock); #1;
                acked |= r0_ack;
            end
            chk("rst pre mem_write", mem_write, 1);
            chk("rst pre busy", busy, 1);
            #2 reset = 1;
            #1;
            chk("rst async mem_write", mem_write, 0);
            chk("rst async busy", busy, 0);
            drive(0, 0, 0, 0, 0);
            @(posedge clock); #1;
            acked |= r0_ack;
            @(negedge clock);
            reset = 0;
            wr_en = 1;
            repeat (3) begin
                @(posedge clock); #1;
                acked |= r0_ack;
            end
            chk("rst no_ack", acked, 0);
            chk("rst mem not written", mem[20], 32'd20);
            txn('{1, 0, 10'h010, 32'h0, 1, 0, 32'd4}, "post_rst r1");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
